riscv_alu_arbiter: RTL

Shares the single combinational `riscv_alu` between two requesters: port 0 is the execute stage and port 1 is the branch/compare unit. It grants the ALU with round-robin priority and registers the operands for one execute cycle. It then returns the result, the zero flag and an illegal-op flag to the winning requester over a valid/ready response channel. It sits between the pipeline control logic and the ALU instance in the CPU top.

---
 rtl/riscv_alu_arbiter_pkg.sv | 43 ++++
 rtl/riscv_alu.sv | 42 ++++
 rtl/riscv_alu_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/riscv_alu_arbiter_pkg.sv
// ============================================================================
// Module      : riscv_alu_arbiter_pkg
// Description : ALU opcodes, arbiter FSM encoding and opcode legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_alu_arbiter_pkg;

    localparam int ALU_OP_LEN = 4;

    localparam logic [ALU_OP_LEN-1:0] ALU_OP_ADD  = 4'd0;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_SUB  = 4'd1;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_AND  = 4'd2;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_OR   = 4'd3;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_XOR  = 4'd4;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_SLL  = 4'd5;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_SRL  = 4'd6;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_SRA  = 4'd7;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_SLT  = 4'd8;
    localparam logic [ALU_OP_LEN-1:0] ALU_OP_SLTU = 4'd9;

    localparam int ARB_ST_LEN = 2;

    typedef enum logic [ARB_ST_LEN-1:0] {
        ARB_ST_IDLE = 2'd0,
        ARB_ST_EXEC = 2'd1,
        ARB_ST_RESP = 2'd2
    } arb_state_t;

    function automatic logic alu_op_is_legal(input logic [ALU_OP_LEN-1:0] op);
        case (op)
            ALU_OP_ADD, ALU_OP_SUB, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR,
            ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_SLT, ALU_OP_SLTU:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_alu.sv
// ============================================================================
// Module      : riscv_alu
// Description : Single-cycle combinational integer ALU with zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_alu
    import riscv_alu_arbiter_pkg::*;
(
    input  logic [ALU_OP_LEN-1:0] alu_op,
    input  logic [31:0]           operand_1,
    input  logic [31:0]           operand_2,
    output logic [31:0]           alu_result,
    output logic                  zero
);

    logic [4:0] w_shamt;
    assign w_shamt = operand_2[4:0];

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_OP_ADD:  alu_result = operand_1 + operand_2;
            ALU_OP_SUB:  alu_result = operand_1 - operand_2;
            ALU_OP_AND:  alu_result = operand_1 & operand_2;
            ALU_OP_OR:   alu_result = operand_1 | operand_2;
            ALU_OP_XOR:  alu_result = operand_1 ^ operand_2;
            ALU_OP_SLL:  alu_result = operand_1 << w_shamt;
            ALU_OP_SRL:  alu_result = operand_1 >> w_shamt;
            ALU_OP_SRA:  alu_result = $unsigned($signed(operand_1) >>> w_shamt);
            ALU_OP_SLT:  alu_result = {31'd0, $signed(operand_1) < $signed(operand_2)};
            ALU_OP_SLTU: alu_result = {31'd0, operand_1 < operand_2};
            default:     alu_result = '0;
        endcase
    end

    assign zero = (alu_result == 32'd0);

endmodule

`default_nettype wire

// File: rtl/riscv_alu_arbiter.sv
// ============================================================================
// Module      : riscv_alu_arbiter
// Description : Round-robin sharing of one riscv_alu between two requesters
//               with a registered execute cycle and valid/ready response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_alu_arbiter
    import riscv_alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ALU_OP_LEN-1:0] req0_alu_op,
    input  logic [31:0]           req0_operand_1,
    input  logic [31:0]           req0_operand_2,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ALU_OP_LEN-1:0] req1_alu_op,
    input  logic [31:0]           req1_operand_1,
    input  logic [31:0]           req1_operand_2,

    output logic                  resp0_valid,
    input  logic                  resp0_ready,
    output logic                  resp1_valid,
    input  logic                  resp1_ready,
    output logic [31:0]           resp_result,
    output logic                  resp_zero,
    output logic                  resp_illegal
);

    localparam int OWNER_W = $clog2(NUM_REQ);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    logic [OWNER_W-1:0]    r_owner;
    logic [OWNER_W-1:0]    r_last_grant;
    logic [ALU_OP_LEN-1:0] r_alu_op;
    logic [31:0]           r_operand_1;
    logic [31:0]           r_operand_2;
    logic [31:0]           r_resp_result;
    logic                  r_resp_zero;
    logic                  r_resp_illegal;

    logic [OWNER_W-1:0]    w_grant;
    logic                  w_resp_hs;
    logic                  w_accept_window;
    logic                  w_accept;
    logic [31:0]           w_alu_result;
    logic                  w_alu_zero;
    logic                  w_illegal;

    // Grant depends only on the valids; on a tie the previous winner yields.
    assign w_grant = (req0_valid && req1_valid) ? ~r_last_grant :
                     (req1_valid ? 1'b1 : 1'b0);

    assign w_resp_hs = (r_state == ARB_ST_RESP) &&
                       ((r_owner == 1'b0) ? resp0_ready : resp1_ready);

    assign w_accept_window = (r_state == ARB_ST_IDLE) || w_resp_hs;

    assign req0_ready = !rst && w_accept_window && req0_valid && (w_grant == 1'b0);
    assign req1_ready = !rst && w_accept_window && req1_valid && (w_grant == 1'b1);
    assign w_accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign resp0_valid  = !rst && (r_state == ARB_ST_RESP) && (r_owner == 1'b0);
    assign resp1_valid  = !rst && (r_state == ARB_ST_RESP) && (r_owner == 1'b1);
    assign resp_result  = r_resp_result;
    assign resp_zero    = r_resp_zero;
    assign resp_illegal = r_resp_illegal;

    riscv_alu u_alu (
        .alu_op     (r_alu_op),
        .operand_1  (r_operand_1),
        .operand_2  (r_operand_2),
        .alu_result (w_alu_result),
        .zero       (w_alu_zero)
    );

    assign w_illegal = !alu_op_is_legal(r_alu_op);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_ST_IDLE: if (w_accept) w_next_state = ARB_ST_EXEC;
            ARB_ST_EXEC: w_next_state = ARB_ST_RESP;
            ARB_ST_RESP: if (w_resp_hs) w_next_state = w_accept ? ARB_ST_EXEC : ARB_ST_IDLE;
            default:     w_next_state = ARB_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ARB_ST_IDLE;
            r_owner        <= '0;
            r_last_grant   <= 1'b1;
            r_alu_op       <= '0;
            r_operand_1    <= '0;
            r_operand_2    <= '0;
            r_resp_result  <= '0;
            r_resp_zero    <= 1'b0;
            r_resp_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
                r_alu_op     <= (w_grant == 1'b0) ? req0_alu_op    : req1_alu_op;
                r_operand_1  <= (w_grant == 1'b0) ? req0_operand_1 : req1_operand_1;
                r_operand_2  <= (w_grant == 1'b0) ? req0_operand_2 : req1_operand_2;
            end
            // An undefined opcode still completes, reporting a forced zero result.
            if (r_state == ARB_ST_EXEC) begin
                r_resp_result  <= w_illegal ? 32'd0 : w_alu_result;
                r_resp_zero    <= w_illegal ? 1'b1  : w_alu_zero;
                r_resp_illegal <= w_illegal;
            end
        end
    end

endmodule

`default_nettype wire
